traffic_phase_monitor: RTL and testbench
========================================

Name: traffic_phase_monitor

Overview:
- Passive checker on the far side of the traffic light controller's output interface. It consumes the controller's side select, state code and R/Y/G lamp outputs.
- Checks lamp sequencing, per-phase dwell times and side rotation order. Raises a sticky error carrying a cause code and a snapshot of the offending interface.
- Counts completed four-side rotations.
- Sits beside the controller in the top-level and bench. Drives nothing back into the controller.

Parameters:
- G_MIN, 4: minimum green dwell, cycles.
- G_MAX, 20: maximum green dwell, cycles.
- Y_MIN, 2: minimum yellow dwell, cycles.
- Y_MAX, 4: maximum yellow dwell, cycles.
- R_MAX, 3: maximum red dwell before the next side's green, cycles.
- CNT_W, 8: dwell counter width. All dwell parameters are below 2^CNT_W - 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  controller run enable; checking is active only while high.
- at_side  input  4  controller side select, one-hot, rotation order 0001->0010->0100->1000->0001.
- at_state  input  4  controller state code; captured for diagnosis only, never decoded.
- R  input  1  red lamp.
- Y  input  1  yellow lamp.
- G  input  1  green lamp.
- active  output  1  monitor is tracking a sequence (state is not IDLE or ERROR).
- err  output  1  sticky violation flag.
- err_code  output  3  cause of the first violation.
- err_side  output  4  at_side sampled in the violating cycle.
- err_state  output  4  at_state sampled in the violating cycle.
- rounds  output  8  completed rotations; wraps 255->0.

Behaviour:
- Reset (reset=0 at a clk edge): FSM goes to IDLE, dwell=0, and the latched side goes to 0000. All outputs go to 0: active, err, err_code, err_side, err_state, rounds.
- FSM states: IDLE, GREEN, YELLOW, RED, ERROR.
- All inputs are sampled on the rising edge. A violation in a sampled cycle updates err and the snapshot at that same edge; it is visible one cycle after the offending values are presented. The FSM enters ERROR at that edge.
- dwell counts cycles in the current lamp state:
  - It is 1 on the first cycle of a lamp and saturates at all-ones.
  - The duration check uses the dwell value held on the last cycle before a lamp change.
- IDLE:
  - Waits for start=1 with G=1, R=0, Y=0 and at_side one-hot. That cycle latches the side, sets dwell=1 and moves to GREEN.
  - Any other lamp pattern in IDLE is ignored. No checks run in IDLE.
- GREEN:
  - G->Y requires G_MIN<=dwell<=G_MAX, then moves to YELLOW.
  - Reaching dwell=G_MAX+1 while G is still on is code 4.
  - G->R is code 3.
- YELLOW:
  - Y->R requires Y_MIN<=dwell<=Y_MAX, then moves to RED.
  - Overrun past Y_MAX, or a dwell below Y_MIN at exit, is code 5.
  - Y->G is code 3.
- RED:
  - R->G moves to GREEN. at_side in the first green cycle must equal the latched side rotated left by 1; otherwise code 7.
  - On a legal R->G, the new side is latched.
  - A new green on side 0001 increments rounds.
  - Red dwell reaching R_MAX+1 is code 6.
  - R->Y is code 3.
- Checks made every cycle in GREEN/YELLOW/RED:
  - {R,Y,G} must be exactly one-hot; otherwise code 1.
  - at_side must be one-hot; otherwise code 2.
  - at_side must not change except on the R->G edge; otherwise code 7.
- Error codes: 0 none, 1 lamp not one-hot, 2 side not one-hot, 3 illegal lamp transition, 4 green dwell, 5 yellow dwell, 6 red dwell, 7 side order.
- Simultaneous violations in one cycle: the lowest nonzero code wins.
- ERROR is absorbing. err, err_code and the snapshot are frozen and rounds holds. Only reset exits.
- start falling while in GREEN/YELLOW/RED: return to IDLE next edge, dwell=0, rounds held, no error.
- start low while in ERROR has no effect.
- active=1 exactly in GREEN, YELLOW and RED.

Test Plan:
- Legal run of G=5, Y=3, R=2 cycles, sides 0001->0010->0100->1000->0001, start=1, reset released -> err stays 0; rounds goes 0->1 on the first-cycle green of side 0001 in the second rotation; active=1 throughout.
- On side 0010, green held 3 cycles then Y -> err=1, err_code=4, err_side=0010 one cycle after the first Y cycle; active=0; rounds frozen.
- G then R with no yellow on side 0100 -> err_code=3, err_side=0100, err_state equal to the at_state driven in the R cycle.
- Red then green on side 0100 after latched side 0001 -> err_code=7. Separately, R and G both high for one cycle -> err_code=1 (wins over 7 if both occur).
- Red held 4 cycles (R_MAX=3) -> err_code=6 on the 4th red cycle. Then drive reset=0 for one edge -> err=0, err_code=0, rounds=0, FSM in IDLE; restart with a legal sequence gives no error.
- Drop start mid-yellow after 2 rotations (rounds=2) -> active=0 next edge, err=0, rounds=2; re-raise start with green on any one-hot side -> tracking resumes.

Source files
------------

// File: rtl/traffic_phase_monitor.sv
// Passive checker for the traffic light controller's output interface: lamp sequencing,
// per-phase dwell limits and side rotation, with a sticky first-error snapshot and rotation count.
module traffic_phase_monitor #(
    parameter int unsigned G_MIN = 4,
    parameter int unsigned G_MAX = 20,
    parameter int unsigned Y_MIN = 2,
    parameter int unsigned Y_MAX = 4,
    parameter int unsigned R_MAX = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] at_side,
    input  logic [3:0] at_state,
    input  logic       R,
    input  logic       Y,
    input  logic       G,
    output logic       active,
    output logic       err,
    output logic [2:0] err_code,
    output logic [3:0] err_side,
    output logic [3:0] err_state,
    output logic [7:0] rounds
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_RED    = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] dwell;
    logic [3:0]       side;

    logic             only_g;
    logic             only_y;
    logic             only_r;
    logic             lamp_ok;
    logic             side_ok;
    logic             tracking;
    logic             rg_edge;
    logic [3:0]       side_exp;
    logic [CNT_W-1:0] dwell_inc;
    logic [7:1]       viol;
    logic [2:0]       code;

    // Per-cycle violation detection; dwell holds the cycles already seen in the current lamp.
    always_comb begin
        only_g    = G & ~Y & ~R;
        only_y    = Y & ~G & ~R;
        only_r    = R & ~G & ~Y;
        lamp_ok   = only_g | only_y | only_r;
        side_ok   = (at_side != 4'd0) && ((at_side & (at_side - 4'd1)) == 4'd0);
        tracking  = (state == S_GREEN) || (state == S_YELLOW) || (state == S_RED);
        rg_edge   = (state == S_RED) && only_g;
        side_exp  = rg_edge ? {side[2:0], side[3]} : side;
        dwell_inc = (&dwell) ? dwell : dwell + CNT_W'(1);

        viol    = '0;
        viol[1] = !lamp_ok;
        viol[2] = !side_ok;
        viol[3] = ((state == S_GREEN)  && only_r) ||
                  ((state == S_YELLOW) && only_g) ||
                  ((state == S_RED)    && only_y);
        viol[4] = (state == S_GREEN) &&
                  ((only_g && (dwell >= CNT_W'(G_MAX))) ||
                   (only_y && ((dwell < CNT_W'(G_MIN)) || (dwell > CNT_W'(G_MAX)))));
        viol[5] = (state == S_YELLOW) &&
                  ((only_y && (dwell >= CNT_W'(Y_MAX))) ||
                   (only_r && ((dwell < CNT_W'(Y_MIN)) || (dwell > CNT_W'(Y_MAX)))));
        viol[6] = (state == S_RED) && only_r && (dwell >= CNT_W'(R_MAX));
        viol[7] = (at_side != side_exp);
        if (!tracking) begin
            viol = '0;
        end

        // Lowest-numbered cause wins.
        code = 3'd0;
        for (int i = 7; i >= 1; i--) begin
            if (viol[i]) begin
                code = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            dwell     <= '0;
            side      <= 4'd0;
            active    <= 1'b0;
            err       <= 1'b0;
            err_code  <= 3'd0;
            err_side  <= 4'd0;
            err_state <= 4'd0;
            rounds    <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && only_g && side_ok) begin
                        state  <= S_GREEN;
                        side   <= at_side;
                        dwell  <= CNT_W'(1);
                        active <= 1'b1;
                    end
                end
                S_GREEN, S_YELLOW, S_RED: begin
                    if (!start) begin
                        state  <= S_IDLE;
                        dwell  <= '0;
                        active <= 1'b0;
                    end else if (code != 3'd0) begin
                        state     <= S_ERROR;
                        active    <= 1'b0;
                        err       <= 1'b1;
                        err_code  <= code;
                        err_side  <= at_side;
                        err_state <= at_state;
                    end else if ((state == S_GREEN) && only_y) begin
                        state <= S_YELLOW;
                        dwell <= CNT_W'(1);
                    end else if ((state == S_YELLOW) && only_r) begin
                        state <= S_RED;
                        dwell <= CNT_W'(1);
                    end else if (rg_edge) begin
                        state <= S_GREEN;
                        dwell <= CNT_W'(1);
                        side  <= at_side;
                        if (at_side == 4'b0001) begin
                            rounds <= rounds + 8'd1;
                        end
                    end else begin
                        dwell <= dwell_inc;
                    end
                end
                S_ERROR: begin
                    state <= S_ERROR;
                end
                default: begin
                    state  <= S_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_phase_monitor.sv
// Bench for traffic_phase_monitor: vector table, directed corner sequences and random
// traffic, all checked against a phase-level reference model.
module tb_traffic_phase_monitor;

    localparam int G_MIN = 4;
    localparam int G_MAX = 20;
    localparam int Y_MIN = 2;
    localparam int Y_MAX = 4;
    localparam int R_MAX = 3;

    localparam logic [2:0] LG = 3'b001;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LR = 3'b100;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] at_side;
    logic [3:0] at_state;
    logic       R;
    logic       Y;
    logic       G;
    logic       active;
    logic       err;
    logic [2:0] err_code;
    logic [3:0] err_side;
    logic [3:0] err_state;
    logic [7:0] rounds;

    int checks   = 0;
    int failures = 0;

    traffic_phase_monitor dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .at_side  (at_side),
        .at_state (at_state),
        .R        (R),
        .Y        (Y),
        .G        (G),
        .active   (active),
        .err      (err),
        .err_code (err_code),
        .err_side (err_side),
        .err_state(err_state),
        .rounds   (rounds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: lamp index 0=G 1=Y 2=R, run length of current lamp, side as index 0..3.
    int m_track, m_err, m_code, m_eside, m_estate, m_rounds, m_lamp, m_run, m_idx;

    function automatic int lamp_max(input int l);
        return (l == 0) ? G_MAX : (l == 1) ? Y_MAX : R_MAX;
    endfunction

    function automatic int lamp_min(input int l);
        return (l == 0) ? G_MIN : (l == 1) ? Y_MIN : 0;
    endfunction

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_step(input bit rs, input bit en, input logic [3:0] sd,
                              input logic [3:0] sc, input logic [2:0] rgy);
        int c, nl, exp_idx;
        bit chg;
        if (!rs) begin
            m_track = 0; m_err = 0; m_code = 0; m_eside = 0; m_estate = 0; m_rounds = 0;
            return;
        end
        if (m_err != 0) return;
        if (m_track == 0) begin
            if (en && rgy == LG && $countones(sd) == 1) begin
                m_track = 1; m_lamp = 0; m_run = 1; m_idx = idx_of(sd);
            end
            return;
        end
        if (!en) begin
            m_track = 0;
            return;
        end
        c = 0;
        if ($countones(rgy) != 1) c = 1;
        else if ($countones(sd) != 1) c = 2;
        else begin
            nl      = rgy[0] ? 0 : (rgy[1] ? 1 : 2);
            chg     = (nl != m_lamp);
            exp_idx = (chg && m_lamp == 2 && nl == 0) ? (m_idx + 1) % 4 : m_idx;
            c = 8;
            if (chg && nl != (m_lamp + 1) % 3) c = 3;
            else if (!chg && m_run + 1 > lamp_max(m_lamp)) c = 4 + m_lamp;
            else if (chg && (m_run < lamp_min(m_lamp) || m_run > lamp_max(m_lamp))) c = 4 + m_lamp;
            if (c == 8 && sd != (4'b0001 << exp_idx)) c = 7;
            if (c == 8) c = 0;
            if (c == 0) begin
                if (chg) begin
                    m_lamp = nl;
                    m_run  = 1;
                    if (nl == 0) begin
                        m_idx = exp_idx;
                        if (m_idx == 0) m_rounds = (m_rounds + 1) % 256;
                    end
                end else begin
                    m_run++;
                end
            end
        end
        if (c != 0) begin
            m_err = 1; m_code = c; m_eside = int'(sd); m_estate = int'(sc); m_track = 0;
        end
    endtask

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle, advance the model, then compare every output against it.
    task automatic step(input bit rs, input bit en, input logic [3:0] sd,
                        input logic [3:0] sc, input logic [2:0] rgy);
        reset = rs; start = en; at_side = sd; at_state = sc; {R, Y, G} = rgy;
        @(posedge clk);
        model_step(rs, en, sd, sc, rgy);
        #1;
        chk("model.active",    8'(active),    8'(m_track));
        chk("model.err",       8'(err),       8'(m_err));
        chk("model.err_code",  8'(err_code),  8'(m_code));
        chk("model.err_side",  8'(err_side),  8'(m_eside));
        chk("model.err_state", 8'(err_state), 8'(m_estate));
        chk("model.rounds",    rounds,        8'(m_rounds));
    endtask

    task automatic ph(input logic [3:0] sd, input logic [2:0] rgy, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, sd, 4'($urandom), rgy);
    endtask

    task automatic rot(input logic [3:0] sd);
        ph(sd, LG, 5);
        ph(sd, LY, 3);
        ph(sd, LR, 2);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 4'd0, 4'd0, 3'b000);
    endtask

    task automatic rand_phases(input int nph);
        logic [3:0] sd;
        logic [2:0] base;
        logic [2:0] rgy;
        logic [3:0] sdrv;
        int len;
        int lamp;
        sd = 4'b0001 << $urandom_range(0, 3);
        for (int p = 0; p < nph; p++) begin
            lamp = p % 3;
            base = (lamp == 0) ? LG : (lamp == 1) ? LY : LR;
            if (lamp == 0)      len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 22) : $urandom_range(4, 7);
            else if (lamp == 1) len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5)  : $urandom_range(2, 4);
            else                len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5)  : $urandom_range(1, 3);
            for (int k = 0; k < len; k++) begin
                rgy  = ($urandom_range(0, 99) < 3) ? 3'($urandom) : base;
                sdrv = ($urandom_range(0, 99) < 2) ? 4'($urandom) : sd;
                step(1'b1, ($urandom_range(0, 199) != 0), sdrv, 4'($urandom), rgy);
            end
            if (lamp == 2)
                sd = ($urandom_range(0, 19) == 0) ? (4'b0001 << $urandom_range(0, 3)) : {sd[2:0], sd[3]};
            if (m_err != 0) begin
                step(1'b1, 1'b1, sd, 4'($urandom), base);
                do_reset();
            end
        end
    endtask

    typedef struct {
        bit         rs;
        bit         en;
        logic [3:0] sd;
        logic [3:0] sc;
        logic [2:0] rgy;
        bit         e_act;
        bit         e_err;
        logic [2:0] e_code;
        logic [3:0] e_side;
        logic [3:0] e_state;
        logic [7:0] e_rounds;
    } vec_t;

    vec_t vt[13];

    initial begin
        //          rs    en    side   st     RYG   act   err   code  eside  estate rounds
        vt[0]  = '{1'b0, 1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 8'd0};
        vt[1]  = '{1'b1, 1'b0, 4'h2, 4'h0, LG,     1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 8'd0};
        vt[2]  = '{1'b1, 1'b1, 4'h2, 4'h1, LG,     1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 8'd0};
        vt[3]  = '{1'b1, 1'b1, 4'h2, 4'h2, LG,     1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 8'd0};
        vt[4]  = '{1'b1, 1'b1, 4'h2, 4'h3, LG,     1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 8'd0};
        vt[5]  = '{1'b1, 1'b1, 4'h2, 4'h5, LY,     1'b0, 1'b1, 3'd4, 4'h2, 4'h5, 8'd0};
        vt[6]  = '{1'b1, 1'b1, 4'h2, 4'h6, LY,     1'b0, 1'b1, 3'd4, 4'h2, 4'h5, 8'd0};
        vt[7]  = '{1'b1, 1'b0, 4'h2, 4'h7, LG,     1'b0, 1'b1, 3'd4, 4'h2, 4'h5, 8'd0};
        vt[8]  = '{1'b0, 1'b1, 4'h2, 4'h7, LG,     1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 8'd0};
        vt[9]  = '{1'b1, 1'b1, 4'h6, 4'h3, LG,     1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 8'd0};
        vt[10] = '{1'b1, 1'b1, 4'h8, 4'h3, 3'b011, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 8'd0};
        vt[11] = '{1'b1, 1'b1, 4'h8, 4'h3, LG,     1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 8'd0};
        vt[12] = '{1'b1, 1'b1, 4'h9, 4'h4, LG,     1'b0, 1'b1, 3'd2, 4'h9, 4'h4, 8'd0};

        reset = 1'b0; start = 1'b0; at_side = 4'd0; at_state = 4'd0; {R, Y, G} = 3'b000;

        for (int i = 0; i < 13; i++) begin
            step(vt[i].rs, vt[i].en, vt[i].sd, vt[i].sc, vt[i].rgy);
            chk($sformatf("vec%0d.active", i),    8'(active),    8'(vt[i].e_act));
            chk($sformatf("vec%0d.err", i),       8'(err),       8'(vt[i].e_err));
            chk($sformatf("vec%0d.err_code", i),  8'(err_code),  8'(vt[i].e_code));
            chk($sformatf("vec%0d.err_side", i),  8'(err_side),  8'(vt[i].e_side));
            chk($sformatf("vec%0d.err_state", i), 8'(err_state), 8'(vt[i].e_state));
            chk($sformatf("vec%0d.rounds", i),    rounds,        vt[i].e_rounds);
        end

        // Legal full rotation; rounds bumps on the next green of side 0001.
        do_reset();
        rot(4'b0001); rot(4'b0010); rot(4'b0100); rot(4'b1000);
        chk("legal.rounds_before", rounds, 8'd0);
        step(1'b1, 1'b1, 4'b0001, 4'h0, LG);
        chk("legal.rounds_after", rounds, 8'd1);
        chk("legal.err", 8'(err), 8'd0);
        chk("legal.active", 8'(active), 8'd1);

        // Short green on side 0010.
        do_reset();
        rot(4'b0001);
        ph(4'b0010, LG, 3);
        step(1'b1, 1'b1, 4'b0010, 4'h3, LY);
        chk("short_green.code", 8'(err_code), 8'd4);
        chk("short_green.side", 8'(err_side), 8'h2);
        chk("short_green.active", 8'(active), 8'd0);
        ph(4'b0010, LY, 2);
        chk("short_green.rounds", rounds, 8'd0);
        chk("short_green.err_held", 8'(err), 8'd1);

        // Green straight to red.
        do_reset();
        ph(4'b0100, LG, 5);
        step(1'b1, 1'b1, 4'b0100, 4'hA, LR);
        chk("g_to_r.code", 8'(err_code), 8'd3);
        chk("g_to_r.side", 8'(err_side), 8'h4);
        chk("g_to_r.state", 8'(err_state), 8'hA);

        // Skipped side in rotation.
        do_reset();
        rot(4'b0001);
        step(1'b1, 1'b1, 4'b0100, 4'h1, LG);
        chk("side_skip.code", 8'(err_code), 8'd7);

        // Two lamps lit together with a wrong side: lamp error wins.
        do_reset();
        ph(4'b0001, LG, 5); ph(4'b0001, LY, 3); ph(4'b0001, LR, 1);
        step(1'b1, 1'b1, 4'b0100, 4'h2, 3'b101);
        chk("two_lamps.code", 8'(err_code), 8'd1);

        // Red overrun, then reset and a clean restart.
        do_reset();
        ph(4'b0001, LG, 5); ph(4'b0001, LY, 3); ph(4'b0001, LR, 3);
        chk("red3.err", 8'(err), 8'd0);
        step(1'b1, 1'b1, 4'b0001, 4'h7, LR);
        chk("red4.code", 8'(err_code), 8'd6);
        do_reset();
        chk("after_reset.err", 8'(err), 8'd0);
        chk("after_reset.code", 8'(err_code), 8'd0);
        chk("after_reset.active", 8'(active), 8'd0);
        rot(4'b0001); rot(4'b0010);
        chk("restart.err", 8'(err), 8'd0);

        // Drop start mid-yellow after two rotations, then resume on another side.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            rot(4'b0001); rot(4'b0010); rot(4'b0100); rot(4'b1000);
        end
        ph(4'b0001, LG, 5);
        chk("two_rot.rounds", rounds, 8'd2);
        ph(4'b0001, LY, 1);
        step(1'b1, 1'b0, 4'b0001, 4'h0, LY);
        chk("stop.active", 8'(active), 8'd0);
        chk("stop.err", 8'(err), 8'd0);
        chk("stop.rounds", rounds, 8'd2);
        step(1'b1, 1'b1, 4'b0100, 4'h0, LG);
        chk("resume.active", 8'(active), 8'd1);
        ph(4'b0100, LG, 4); ph(4'b0100, LY, 3); ph(4'b0100, LR, 2); ph(4'b1000, LG, 5);
        chk("resume.err", 8'(err), 8'd0);
        chk("resume.rounds", rounds, 8'd2);

        // Random traffic against the model.
        do_reset();
        rand_phases(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
